// File: rtl/srff_bank.sv
`default_nettype none
// ============================================================================
// Module   : srff_bank
// Brief    : Bank of WIDTH clocked set/reset flip-flops with input synchroniser,
//            optional rising-edge trigger, selectable S/R conflict resolution,
//            per-channel change/conflict pulses and a saturating conflict count.
// Revision : 1.0 - initial release
// ============================================================================
module srff_bank #(
    parameter int               WIDTH       = 4,
    parameter int               PRIO        = 0,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE        = 0,
    parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] chg,
    output logic [WIDTH-1:0] conflict,
    output logic [7:0]       conflict_cnt
);

    localparam int         c_PRIO_RESET  = 0;
    localparam int         c_PRIO_SET    = 1;
    localparam int         c_PRIO_TOGGLE = 2;
    localparam logic [7:0] c_CNT_MAX     = 8'hFF;

    logic [WIDTH-1:0] w_s_sync;
    logic [WIDTH-1:0] w_r_sync;
    logic [WIDTH-1:0] w_s_act;
    logic [WIDTH-1:0] w_r_act;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_conflict_next;
    logic [WIDTH-1:0] w_chg_next;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qn;
    logic [WIDTH-1:0] r_chg;
    logic [WIDTH-1:0] r_conflict;
    logic [7:0]       r_cnt;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign w_s_sync = s;
            assign w_r_sync = r;
        end else begin : g_sync
            logic [WIDTH-1:0] r_s_pipe [SYNC_STAGES];
            logic [WIDTH-1:0] r_r_pipe [SYNC_STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_s_pipe[i] <= '0;
                        r_r_pipe[i] <= '0;
                    end
                end else begin
                    r_s_pipe[0] <= s;
                    r_r_pipe[0] <= r;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_s_pipe[i] <= r_s_pipe[i-1];
                        r_r_pipe[i] <= r_r_pipe[i-1];
                    end
                end
            end

            assign w_s_sync = r_s_pipe[SYNC_STAGES-1];
            assign w_r_sync = r_r_pipe[SYNC_STAGES-1];
        end
    endgenerate

    generate
        if (EDGE == 1) begin : g_edge
            // prev flops run regardless of en, so edges seen while disabled are dropped
            logic [WIDTH-1:0] r_s_prev;
            logic [WIDTH-1:0] r_r_prev;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s_prev <= '0;
                    r_r_prev <= '0;
                end else begin
                    r_s_prev <= w_s_sync;
                    r_r_prev <= w_r_sync;
                end
            end

            assign w_s_act = w_s_sync & ~r_s_prev;
            assign w_r_act = w_r_sync & ~r_r_prev;
        end else begin : g_level
            assign w_s_act = w_s_sync;
            assign w_r_act = w_r_sync;
        end
    endgenerate

    always_comb begin
        w_q_next        = r_q;
        w_conflict_next = '0;
        if (en) begin
            w_conflict_next = w_s_act & w_r_act;
            for (int i = 0; i < WIDTH; i++) begin
                case ({w_s_act[i], w_r_act[i]})
                    2'b10: w_q_next[i] = 1'b1;
                    2'b01: w_q_next[i] = 1'b0;
                    2'b11: begin
                        if (PRIO == c_PRIO_RESET) begin
                            w_q_next[i] = 1'b0;
                        end else if (PRIO == c_PRIO_SET) begin
                            w_q_next[i] = 1'b1;
                        end else if (PRIO == c_PRIO_TOGGLE) begin
                            w_q_next[i] = ~r_q[i];
                        end else begin
                            w_q_next[i] = r_q[i];
                        end
                    end
                    default: w_q_next[i] = r_q[i];
                endcase
            end
        end
        w_chg_next = w_q_next ^ r_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= INIT;
            r_qn       <= ~INIT;
            r_chg      <= '0;
            r_conflict <= '0;
            r_cnt      <= '0;
        end else begin
            r_q        <= w_q_next;
            r_qn       <= ~w_q_next;
            r_chg      <= w_chg_next;
            r_conflict <= w_conflict_next;
            // clear beats a same-cycle increment
            if (clr_cnt) begin
                r_cnt <= '0;
            end else if ((|w_conflict_next) && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign q            = r_q;
    assign qn           = r_qn;
    assign chg          = r_chg;
    assign conflict     = r_conflict;
    assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_srff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_srff_bank
// Brief    : Scoreboard bench for srff_bank; five configurations share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srff_bank;

    localparam int N    = 5;
    localparam int HMAX = 4096;

    localparam int         P_PRIO [N] = '{0, 1, 2, 3, 0};
    localparam int         P_SS   [N] = '{2, 1, 0, 3, 0};
    localparam int         P_EDGE [N] = '{0, 1, 0, 0, 1};
    localparam logic [3:0] P_INIT [N] = '{4'h0, 4'h5, 4'hA, 4'h3, 4'h0};

    typedef struct packed {
        logic [N-1:0][3:0] q;
        logic [N-1:0][3:0] qn;
        logic [N-1:0][3:0] chg;
        logic [N-1:0][3:0] conf;
        logic [N-1:0][7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [3:0] s;
    logic [3:0] r;

    logic [3:0] q_o    [N];
    logic [3:0] qn_o   [N];
    logic [3:0] chg_o  [N];
    logic [3:0] conf_o [N];
    logic [7:0] cnt_o  [N];

    int checks = 0;
    int errors = 0;

    exp_t exp_q [$];

    // input history, one entry per rising edge
    logic [3:0] h_s   [HMAX];
    logic [3:0] h_r   [HMAX];
    logic       h_rst [HMAX];
    int         k = 0;

    logic [3:0] m_q   [N];
    logic [7:0] m_cnt [N];

    always #5 clk = ~clk;

    srff_bank #(.WIDTH(4), .PRIO(0), .SYNC_STAGES(2), .EDGE(0), .INIT(4'h0)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr),
        .q(q_o[0]), .qn(qn_o[0]), .chg(chg_o[0]), .conflict(conf_o[0]), .conflict_cnt(cnt_o[0]));
    srff_bank #(.WIDTH(4), .PRIO(1), .SYNC_STAGES(1), .EDGE(1), .INIT(4'h5)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr),
        .q(q_o[1]), .qn(qn_o[1]), .chg(chg_o[1]), .conflict(conf_o[1]), .conflict_cnt(cnt_o[1]));
    srff_bank #(.WIDTH(4), .PRIO(2), .SYNC_STAGES(0), .EDGE(0), .INIT(4'hA)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr),
        .q(q_o[2]), .qn(qn_o[2]), .chg(chg_o[2]), .conflict(conf_o[2]), .conflict_cnt(cnt_o[2]));
    srff_bank #(.WIDTH(4), .PRIO(3), .SYNC_STAGES(3), .EDGE(0), .INIT(4'h3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr),
        .q(q_o[3]), .qn(qn_o[3]), .chg(chg_o[3]), .conflict(conf_o[3]), .conflict_cnt(cnt_o[3]));
    srff_bank #(.WIDTH(4), .PRIO(0), .SYNC_STAGES(0), .EDGE(1), .INIT(4'h0)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_cnt(clr),
        .q(q_o[4]), .qn(qn_o[4]), .chg(chg_o[4]), .conflict(conf_o[4]), .conflict_cnt(cnt_o[4]));

    task automatic cmp(input string nm, input int n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] t=%0t got %h expected %h", nm, n, $time, act, exp);
        end
    endtask

    // Synchronised value seen at edge j: the raw input from ss edges earlier,
    // or zero if a reset hit the synchroniser since then.
    function automatic logic [3:0] sync_at(input int ss, input int j, input bit is_s);
        if (j - ss < 0) return 4'h0;
        for (int t = j - ss; t < j; t++)
            if (h_rst[t]) return 4'h0;
        return is_s ? h_s[j-ss] : h_r[j-ss];
    endfunction

    function automatic logic [3:0] act_at(input int n, input int j, input bit is_s);
        logic [3:0] cur;
        logic [3:0] prev;
        cur = sync_at(P_SS[n], j, is_s);
        if (P_EDGE[n] == 0) return cur;
        prev = (j < 1 || h_rst[j-1]) ? 4'h0 : sync_at(P_SS[n], j - 1, is_s);
        return cur & ~prev;
    endfunction

    // reference model: computes what each DUT should show after this edge
    initial begin
        exp_t       e;
        logic [3:0] sa, ra, qnew;
        forever begin
            @(posedge clk);
            h_s[k] = s; h_r[k] = r; h_rst[k] = rst;
            e = '0;
            for (int n = 0; n < N; n++) begin
                if (rst) begin
                    m_q[n]   = P_INIT[n];
                    m_cnt[n] = 8'd0;
                end else begin
                    qnew = m_q[n];
                    if (en) begin
                        sa = act_at(n, k, 1'b1);
                        ra = act_at(n, k, 1'b0);
                        e.conf[n] = sa & ra;
                        for (int i = 0; i < 4; i++) begin
                            if (sa[i] && !ra[i]) qnew[i] = 1'b1;
                            else if (ra[i] && !sa[i]) qnew[i] = 1'b0;
                            else if (sa[i] && ra[i]) begin
                                case (P_PRIO[n])
                                    0: qnew[i] = 1'b0;
                                    1: qnew[i] = 1'b1;
                                    2: qnew[i] = ~m_q[n][i];
                                    default: qnew[i] = m_q[n][i];
                                endcase
                            end
                        end
                    end
                    e.chg[n] = qnew ^ m_q[n];
                    m_q[n] = qnew;
                    if (clr) m_cnt[n] = 8'd0;
                    else if (e.conf[n] != 4'h0 && m_cnt[n] < 8'd255) m_cnt[n] = m_cnt[n] + 8'd1;
                end
                e.q[n]   = m_q[n];
                e.qn[n]  = ~m_q[n];
                e.cnt[n] = m_cnt[n];
            end
            exp_q.push_back(e);
            if (k < HMAX - 1) k++;
        end
    end

    // monitor: one expected record per edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard t=%0t got empty queue expected a record", $time);
            end else begin
                e = exp_q.pop_front();
                for (int n = 0; n < N; n++) begin
                    cmp("q",    n, {4'h0, q_o[n]},    {4'h0, e.q[n]});
                    cmp("qn",   n, {4'h0, qn_o[n]},   {4'h0, e.qn[n]});
                    cmp("chg",  n, {4'h0, chg_o[n]},  {4'h0, e.chg[n]});
                    cmp("conf", n, {4'h0, conf_o[n]}, {4'h0, e.conf[n]});
                    cmp("cnt",  n, cnt_o[n],          e.cnt[n]);
                end
            end
        end
    end

    task automatic cycles(input int c);
        repeat (c) @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] sv, input logic [3:0] rv, input int c);
        s = sv;
        r = rv;
        cycles(c);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; s = 4'hF; r = 4'hF;
        #1;
        for (int n = 0; n < N; n++) begin
            cmp("rst_q",   n, {4'h0, q_o[n]},  {4'h0, P_INIT[n]});
            cmp("rst_qn",  n, {4'h0, qn_o[n]}, {4'h0, ~P_INIT[n]});
            cmp("rst_cnt", n, cnt_o[n], 8'd0);
        end
        cycles(4);
        rst = 1'b0;
        cycles(6);

        // classic RS sweep
        for (int i = 0; i < 16; i++) begin
            logic [4:0] sv;
            sv = 5'd17 - 5'(i);
            drive(sv[3:0], 4'(i), 10);
        end

        // conflict resolution from Q=0 with S=R held
        drive(4'h0, 4'hF, 6);
        drive(4'hF, 4'hF, 8);
        drive(4'h0, 4'h0, 4);

        // edges arriving while disabled are lost
        drive(4'hF, 4'h0, 10);
        en = 1'b0;
        drive(4'hF, 4'hF, 3);
        drive(4'hF, 4'h0, 2);
        en = 1'b1;
        cycles(6);

        // counter saturation, then clear during an ongoing conflict
        drive(4'h0, 4'h0, 4);
        drive(4'hF, 4'hF, 300);
        clr = 1'b1;
        cycles(1);
        clr = 1'b0;
        cycles(4);

        // asynchronous reset between edges
        drive(4'hA, 4'h5, 8);
        #2;
        rst = 1'b1;
        #1;
        for (int n = 0; n < N; n++) begin
            cmp("arst_q",   n, {4'h0, q_o[n]},  {4'h0, P_INIT[n]});
            cmp("arst_qn",  n, {4'h0, qn_o[n]}, {4'h0, ~P_INIT[n]});
            cmp("arst_chg", n, {4'h0, chg_o[n]}, 8'd0);
            cmp("arst_cnt", n, cnt_o[n], 8'd0);
        end
        cycles(2);
        rst = 1'b0;

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            s   = 4'($urandom);
            r   = 4'($urandom);
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycles(1);
        end
        rst = 1'b0; en = 1'b1; clr = 1'b0;
        cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/srff_bank.md
# srff_bank

Parametrised, clocked bank of WIDTH independent set/reset flip-flops. It succeeds the 4-bit cross-coupled RS latch. It adds:
- input synchronisation;
- selectable conflict resolution (reset-dominant, set-dominant, toggle, hold);
- optional rising-edge triggering;
- per-channel change and conflict pulses;
- a saturating conflict counter.

It sits between asynchronous control/status lines and synchronous logic that needs sticky, glitch-free state bits.

## Interface
- WIDTH, 4: number of channels (1..32).
- PRIO, 0: action when S and R are both active. 0 = reset wins, 1 = set wins, 2 = toggle, 3 = hold.
- SYNC_STAGES, 2: synchroniser depth on S and R (0..3). 0 means inputs are used directly.
- EDGE, 0: trigger type. 0 = level (active while high), 1 = rising-edge (active for one cycle on a 0→1 transition of the synchronised input).
- INIT, {WIDTH{1'b0}}: Q value loaded by reset.
- CLK  input  1  clock. All state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- EN  input  1  global update enable.
- S  input  WIDTH  per-channel set request.
- R  input  WIDTH  per-channel reset request.
- CLR_CNT  input  1  synchronous clear of CONFLICT_CNT.
- Q  output  WIDTH  flip-flop state.
- QN  output  WIDTH  always ~Q (registered alongside Q, never combinational from S/R).
- CHG  output  WIDTH  one-cycle pulse in the cycle Q[i] first shows a new value.
- CONFLICT  output  WIDTH  one-cycle pulse: S and R were both active on the channel in the evaluated cycle.
- CONFLICT_CNT  output  8  count of cycles in which any channel had a conflict; saturates at 255.

## Operation
- Input path per channel:
  - S and R each pass through SYNC_STAGES flops (reset to 0) to give s_sync and r_sync.
  - EDGE=1: s_act = s_sync & ~s_prev, where s_prev is the previous s_sync (reset 0). Same for r_act.
  - EDGE=0: s_act = s_sync and r_act = r_sync.
- Next-state per channel, when EN=1:
  - s_act only: Q ← 1.
  - r_act only: Q ← 0.
  - Neither: Q holds.
  - Both: apply PRIO. Reset-dominant → 0. Set-dominant → 1. Toggle → ~Q. Hold → Q.
- CHG[i] and CONFLICT[i] are registered with the Q update.
  - CHG[i] = 1 only if Q[i] actually changed value. Setting an already-set Q gives no CHG.
  - CONFLICT[i] = s_act & r_act & EN.
- EN=0:
  - Q, QN hold.
  - CHG and CONFLICT are 0.
  - Counter does not increment.
  - The synchronisers and s_prev/r_prev keep running, so edges arriving while EN=0 are lost, not queued.
- CONFLICT_CNT:
  - Increments by 1 in each clock where |CONFLICT_next is true. The count is per cycle, not per channel.
  - Holds at 255 once reached.
  - CLR_CNT=1 forces 0 on the next edge and takes priority over a same-cycle increment.
- Channels are fully independent. Only EN, CLR_CNT and the counter are shared.

## Timing
- Reset values (asynchronous, immediate on RST=1):
  - Q=INIT, QN=~INIT.
  - CHG=0, CONFLICT=0, CONFLICT_CNT=0.
  - All sync and prev flops are 0.
- Latency from an S/R change at the input to the corresponding Q, CHG and CONFLICT: SYNC_STAGES+1 rising edges. SYNC_STAGES=0 gives 1 edge.
- EDGE=1 with an input held high across reset release: the synchroniser fills from 0, so one rising edge is seen SYNC_STAGES+1 clocks after release and acts once.
- EDGE=1 with an input held high: acts once only. It must go low for at least one synchronised cycle before it can act again.
- Toggle mode (PRIO=2) with EDGE=0 and S=R=1 held: Q toggles every cycle and CHG pulses every cycle.
- Pulses narrower than one CLK period may be missed. This is specified behaviour, not a fault.
- RST asserted mid-operation: all outputs revert within the same cycle. No update occurs on the edge where RST is high.

## Test plan
- Reset sweep: WIDTH=4, PRIO=0, SYNC_STAGES=2, EDGE=0. Hold RST with R=4'hF, S=4'hF.
  - Required: Q=0, QN=F, CONFLICT_CNT=0 throughout reset.
  - After release: CONFLICT=F on edge 3, and CONFLICT_CNT increments each cycle.
- Classic RS sweep with the same config, for I=0..15: R=I, S=17-I (mod 16), each held 10 cycles.
  - Required: Q=S&~R, appearing 3 edges after each step.
  - CHG flags exactly the bits that differ from the previous Q.
- Priority modes, one channel:
  - S=R=1 from Q=0: PRIO=1 → Q=1. PRIO=3 → Q stays 0 with CHG=0.
  - PRIO=2, EDGE=0, S=R=1 held 5 cycles → Q alternates 1,0,1,0,1 with CHG=1 each cycle.
- Edge mode, EDGE=1, SYNC_STAGES=0:
  - S high for 10 cycles → Q=1 after 1 edge, with a single CHG pulse.
  - R pulse while EN=0 → Q stays 1. That edge is not replayed after EN returns to 1.
- Counter:
  - Force a conflict for 300 cycles → CONFLICT_CNT reaches 255 and holds.
  - CLR_CNT=1 in the same cycle as a conflict → CONFLICT_CNT=0 on the next edge, then 1 on the following edge if the conflict persists.
- Async reset mid-run: assert RST between clock edges while Q=4'hA, INIT=4'h5.
  - Required: Q=5 and QN=A immediately, without waiting for CLK.
